// File: rtl/serial_ripple_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master issues requests and the slave (the subtractor) returns results.
interface serial_ripple_subtractor_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout
   );
endinterface

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor computing diff = a - b - bin one bit per clock with a
// single borrow flop; the low APPROX_BITS positions drop their borrow-out.
module serial_ripple_subtractor #(
   parameter int WIDTH       = 4,
   parameter int APPROX_BITS = 0
) (
   input logic                     clk,
   input logic                     rst,
   serial_ripple_subtractor_if.slave bus
);
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [WIDTH-1:0] res_next;
   logic [WIDTH-1:0] diff_q;
   logic [IDX_W-1:0] idx;
   logic             br;
   logic             bout_q;
   logic             bit_d;
   logic             bit_br;
   logic             br_next;
   logic             accept;
   logic             last_bit;

   // Operands shift right so bit i is always at position 0 during RUN.
   assign bit_d    = a_sh[0] ^ b_sh[0] ^ br;
   assign bit_br   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
   assign br_next  = (int'(idx) < APPROX_BITS) ? 1'b0 : bit_br;
   assign res_next = (res_sh >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));
   assign last_bit = (idx == IDX_W'(WIDTH - 1));

   assign bus.busy = (state == RUN);
   assign bus.done = (state == DONE);
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept     = 1'b1;
               next_state = RUN;
            end
         end
         RUN: begin
            if (last_bit) begin
               next_state = DONE;
            end
         end
         DONE: begin
            // A start seen in DONE chains straight into the next operation.
            if (bus.start) begin
               accept     = 1'b1;
               next_state = RUN;
            end else begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         diff_q <= '0;
         idx    <= '0;
         br     <= 1'b0;
         bout_q <= 1'b0;
      end else if (accept) begin
         a_sh   <= bus.a;
         b_sh   <= bus.b;
         br     <= bus.bin;
         idx    <= '0;
         res_sh <= '0;
      end else if (state == RUN) begin
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         br     <= br_next;
         idx    <= idx + 1'b1;
         res_sh <= res_next;
         if (last_bit) begin
            diff_q <= res_next;
            bout_q <= br_next;
         end
      end
   end
endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Scoreboard bench: exact, 2-bit and 4-bit approximate subtractors share one
// stimulus stream; per-instance monitors pop expected results on each done.
module tb_serial_ripple_subtractor;
   localparam int W = 4;

   typedef struct {
      logic [W-1:0] diff;
      logic         bout;
      int           cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         op_start = 1'b0;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         op_bin = 1'b0;
   int           cyc = 0;
   int           checks = 0;
   int           fails = 0;
   int           done0_count = 0;
   exp_t         q0[$];
   exp_t         q2[$];
   exp_t         q4[$];

   serial_ripple_subtractor_if #(.WIDTH(W)) bus0 ();
   serial_ripple_subtractor_if #(.WIDTH(W)) bus2 ();
   serial_ripple_subtractor_if #(.WIDTH(W)) bus4 ();

   assign bus0.start = op_start;
   assign bus0.a     = op_a;
   assign bus0.b     = op_b;
   assign bus0.bin   = op_bin;
   assign bus2.start = op_start;
   assign bus2.a     = op_a;
   assign bus2.b     = op_b;
   assign bus2.bin   = op_bin;
   assign bus4.start = op_start;
   assign bus4.a     = op_a;
   assign bus4.b     = op_b;
   assign bus4.bin   = op_bin;

   serial_ripple_subtractor #(.WIDTH(W), .APPROX_BITS(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   serial_ripple_subtractor #(.WIDTH(W), .APPROX_BITS(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
   serial_ripple_subtractor #(.WIDTH(W), .APPROX_BITS(W)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Borrow-chain model with the low nb borrow-outs suppressed.
   function automatic logic [W:0] approx_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic bin, input int nb);
      logic         br = bin;
      logic         brn;
      logic [W-1:0] r = '0;
      for (int i = 0; i < W; i++) begin
         r[i] = a[i] ^ b[i] ^ br;
         brn  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
         br   = (i < nb) ? 1'b0 : brn;
      end
      return {br, r};
   endfunction

   task automatic push_expected(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                input logic [W-1:0] exp_diff, input logic exp_bout, input int done_cyc);
      exp_t         e;
      logic [W:0]   m;
      e.diff = exp_diff;
      e.bout = exp_bout;
      e.cyc  = done_cyc;
      q0.push_back(e);
      m      = approx_model(a, b, bin, 2);
      e.diff = m[W-1:0];
      e.bout = m[W];
      q2.push_back(e);
      m      = approx_model(a, b, bin, W);
      e.diff = m[W-1:0];
      e.bout = m[W];
      q4.push_back(e);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while ((bus0.busy || bus0.done) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check_output("wait_idle_timeout", 1, 0);
   endtask

   // Issues one operation from IDLE; returns one step into the first RUN cycle.
   task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                 input logic [W-1:0] exp_diff, input logic exp_bout);
      wait_idle();
      op_a     = a;
      op_b     = b;
      op_bin   = bin;
      op_start = 1'b1;
      push_expected(a, b, bin, exp_diff, exp_bout, cyc + W + 1);
      @(posedge clk);
      #1 op_start = 1'b0;
   endtask

   always @(negedge clk) begin : mon0
      exp_t e;
      if (!rst && bus0.done) begin
         done0_count++;
         check_output("dut0_busy_with_done", 32'(bus0.busy), 0);
         if (q0.size() == 0) begin
            check_output("dut0_unexpected_done", 1, 0);
         end else begin
            e = q0.pop_front();
            check_output("dut0_diff", 32'(bus0.diff), 32'(e.diff));
            check_output("dut0_bout", 32'(bus0.bout), 32'(e.bout));
            check_output("dut0_done_cycle", cyc, e.cyc);
         end
      end
   end

   always @(negedge clk) begin : mon2
      exp_t e;
      if (!rst && bus2.done) begin
         if (q2.size() == 0) begin
            check_output("dut2_unexpected_done", 1, 0);
         end else begin
            e = q2.pop_front();
            check_output("dut2_diff", 32'(bus2.diff), 32'(e.diff));
            check_output("dut2_bout", 32'(bus2.bout), 32'(e.bout));
         end
      end
   end

   always @(negedge clk) begin : mon4
      exp_t e;
      if (!rst && bus4.done) begin
         if (q4.size() == 0) begin
            check_output("dut4_unexpected_done", 1, 0);
         end else begin
            e = q4.pop_front();
            check_output("dut4_diff", 32'(bus4.diff), 32'(e.diff));
            check_output("dut4_bout", 32'(bus4.bout), 32'(e.bout));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int         snap;
      int         acc;
      int         n;
      logic [W:0] full;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_output("reset_busy", 32'(bus0.busy), 0);
      check_output("reset_done", 32'(bus0.done), 0);
      check_output("reset_diff", 32'(bus0.diff), 0);
      check_output("reset_bout", 32'(bus0.bout), 0);
      rst = 1'b0;

      apply_stimulus(4'd9, 4'd3, 1'b0, 4'd6, 1'b0);
      for (int k = 1; k <= W + 1; k++) begin
         @(negedge clk);
         check_output($sformatf("busy_cycle%0d", k), 32'(bus0.busy), (k <= W) ? 1 : 0);
      end

      apply_stimulus(4'd3, 4'd9, 1'b0, 4'd10, 1'b1);
      apply_stimulus(4'd0, 4'd0, 1'b1, 4'd15, 1'b1);

      apply_stimulus(4'd4, 4'd1, 1'b0, 4'd3, 1'b0);
      wait_idle();
      check_output("approx2_diff", 32'(bus2.diff), 5);
      check_output("approx2_bout", 32'(bus2.bout), 0);

      apply_stimulus(4'd0, 4'd1, 1'b0, 4'd15, 1'b1);
      wait_idle();
      check_output("approx4_diff", 32'(bus4.diff), 1);
      check_output("approx4_bout", 32'(bus4.bout), 0);

      // Abort an operation in its second RUN cycle; no result may appear.
      wait_idle();
      op_a     = 4'd9;
      op_b     = 4'd3;
      op_bin   = 1'b0;
      op_start = 1'b1;
      @(posedge clk);
      #1 op_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      snap     = done0_count;
      rst      = 1'b1;
      op_start = 1'b1;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      op_start = 1'b0;
      @(negedge clk);
      check_output("abort_busy", 32'(bus0.busy), 0);
      check_output("abort_done", 32'(bus0.done), 0);
      check_output("abort_diff", 32'(bus0.diff), 0);
      check_output("abort_bout", 32'(bus0.bout), 0);
      repeat (6) @(negedge clk);
      check_output("abort_no_done", done0_count, snap);
      apply_stimulus(4'd9, 4'd3, 1'b0, 4'd6, 1'b0);

      // A start pulse in RUN cycle 2 with new operands must be ignored.
      apply_stimulus(4'd12, 4'd5, 1'b1, 4'd6, 1'b0);
      @(negedge clk);
      @(negedge clk);
      op_a     = 4'd1;
      op_b     = 4'd1;
      op_bin   = 1'b0;
      op_start = 1'b1;
      @(posedge clk);
      #1 op_start = 1'b0;
      repeat (5) @(negedge clk);
      check_output("ignored_start_idle", 32'(bus0.busy), 0);

      // start held through DONE chains a second operation.
      wait_idle();
      acc      = cyc;
      op_a     = 4'd7;
      op_b     = 4'd2;
      op_bin   = 1'b0;
      op_start = 1'b1;
      push_expected(4'd7, 4'd2, 1'b0, 4'd5, 1'b0, acc + W + 1);
      @(posedge clk);
      #1;
      op_a  = 4'd15;
      op_b  = 4'd14;
      push_expected(4'd15, 4'd14, 1'b0, 4'd1, 1'b0, acc + 2 * (W + 1));
      repeat (W + 1) @(posedge clk);
      #1 op_start = 1'b0;

      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            for (int ci = 0; ci < 2; ci++) begin
               full = {1'b0, 4'(ai)} - {1'b0, 4'(bi)} - 5'(ci);
               apply_stimulus(4'(ai), 4'(bi), 1'(ci), full[W-1:0], full[W]);
            end
         end
      end

      n = 0;
      while ((q0.size() + q2.size() + q4.size()) != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_output("queues_drained", q0.size() + q2.size() + q4.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
